// File: rtl/zap_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : zap_register_file_mp
// Purpose  : Parametrised flip-flop register file with NUM_RD read ports,
//            two indexed write ports (A, B), one multi-hot bulk write port (C),
//            optional same-cycle write-to-read bypass, optional registered
//            read, a sequenced soft-clear engine and a sticky out-of-range
//            error flag.
// Ports    :
//   i_clk, i_reset              clock / asynchronous active-high reset
//   i_wen                       qualifies write ports A and B
//   i_wr_addr_a/_b, i_wr_data_a/_b   indexed write ports
//   i_wr_addr_c, i_wr_data_c    multi-hot mask write port (not gated by i_wen)
//   i_rd_addr, o_rd_data        packed read indices / read data
//   i_clr_req                   start a soft clear
//   o_clr_busy, o_clr_done      soft clear in progress / completion pulse
//   o_addr_err                  sticky out-of-range index flag
// Revision : 1.0 - initial release
// ============================================================================
module zap_register_file_mp #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 40,
    parameter  int NUM_RD = 4,
    parameter  int BYPASS = 1,
    parameter  int RD_REG = 0,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_wen,
    input  logic [ADDR_W-1:0]          i_wr_addr_a,
    input  logic [DATA_W-1:0]          i_wr_data_a,
    input  logic [ADDR_W-1:0]          i_wr_addr_b,
    input  logic [DATA_W-1:0]          i_wr_data_b,
    input  logic [DEPTH-1:0]           i_wr_addr_c,
    input  logic [DATA_W-1:0]          i_wr_data_c,
    input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
    input  logic                       i_clr_req,
    output logic                       o_clr_busy,
    output logic                       o_clr_done,
    output logic                       o_addr_err
);

    localparam logic [1:0]        S_IDLE   = 2'd0;
    localparam logic [1:0]        S_CLEAR  = 2'd1;
    localparam logic [1:0]        S_DONE   = 2'd2;
    localparam logic [ADDR_W-1:0] C_PTR_LAST = ADDR_W'(DEPTH - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic              w_clr_we;
    logic              w_clr_finish;

    logic [DATA_W-1:0] r_mem     [DEPTH];
    logic [DATA_W-1:0] w_mem_nxt [DEPTH];

    logic [NUM_RD-1:0] w_rd_oor;
    logic              w_wr_oor;
    logic              w_err_evt;
    logic              r_addr_err;

    // Index is out of range when it is >= DEPTH. One extra bit keeps the
    // compare exact even when DEPTH is a power of two.
    function automatic logic f_oor(input logic [ADDR_W-1:0] idx);
        return ({1'b0, idx} >= (ADDR_W + 1)'(DEPTH));
    endfunction

    // ------------------------------------------------------------------------
    // Soft-clear FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Soft-clear FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_clr_req) w_state_nxt = S_CLEAR;
            S_CLEAR: if (r_clr_ptr == C_PTR_LAST) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Soft-clear FSM: outputs
    always_comb begin
        o_clr_busy   = (r_state == S_CLEAR);
        o_clr_done   = (r_state == S_DONE);
        w_clr_we     = (r_state == S_CLEAR);
        w_clr_finish = (r_state == S_CLEAR) && (r_clr_ptr == C_PTR_LAST);
    end

    // Clear pointer: restarts at 0 on each request and parks on the last
    // entry, so it never wraps.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_clr_ptr <= '0;
        end else if ((r_state == S_IDLE) && i_clr_req) begin
            r_clr_ptr <= '0;
        end else if ((r_state == S_CLEAR) && (r_clr_ptr != C_PTR_LAST)) begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state value of every entry. Later assignments win, so the order
    // below encodes priority: clear engine < A < B < C. Out-of-range A/B
    // indices never match an entry and are therefore dropped.
    // ------------------------------------------------------------------------
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            w_mem_nxt[e] = r_mem[e];
            if (w_clr_we && (r_clr_ptr == ADDR_W'(e))) begin
                w_mem_nxt[e] = '0;
            end
            if (i_wen && (i_wr_addr_a == ADDR_W'(e))) begin
                w_mem_nxt[e] = i_wr_data_a;
            end
            if (i_wen && (i_wr_addr_b == ADDR_W'(e))) begin
                w_mem_nxt[e] = i_wr_data_b;
            end
            if (i_wr_addr_c[e]) begin
                w_mem_nxt[e] = i_wr_data_c;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                r_mem[e] <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                r_mem[e] <= w_mem_nxt[e];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_oor;
        logic [DATA_W-1:0] w_data;

        assign w_addr      = i_rd_addr[k*ADDR_W +: ADDR_W];
        assign w_oor       = f_oor(w_addr);
        assign w_rd_oor[k] = w_oor;

        // Bypass returns the value the entry holds after this edge, which
        // already folds in C/B/A priority and the clear engine.
        always_comb begin
            w_data = '0;
            if (!w_oor) begin
                w_data = (BYPASS != 0) ? w_mem_nxt[w_addr] : r_mem[w_addr];
            end
        end

        if (RD_REG != 0) begin : g_reg
            logic [DATA_W-1:0] r_data;
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_data <= '0;
                end else begin
                    r_data <= w_data;
                end
            end
            assign o_rd_data[k*DATA_W +: DATA_W] = r_data;
        end else begin : g_comb
            assign o_rd_data[k*DATA_W +: DATA_W] = w_data;
        end
    end

    // ------------------------------------------------------------------------
    // Sticky address error. A fresh error on the completion edge wins over
    // the completion clear so that it is never lost.
    // ------------------------------------------------------------------------
    assign w_wr_oor  = i_wen && (f_oor(i_wr_addr_a) || f_oor(i_wr_addr_b));
    assign w_err_evt = w_wr_oor || (|w_rd_oor);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_addr_err <= 1'b0;
        end else if (w_err_evt) begin
            r_addr_err <= 1'b1;
        end else if (w_clr_finish) begin
            r_addr_err <= 1'b0;
        end
    end

    assign o_addr_err = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_zap_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_zap_register_file_mp
// Purpose  : Self-checking bench. Two instances share all inputs: one with
//            bypass and combinational read, one without bypass and with
//            registered read. A behavioural model of the file is compared
//            against both on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zap_register_file_mp;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 40;
    localparam int NUM_RD = 4;
    localparam int ADDR_W = 6;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     wen;
    logic [ADDR_W-1:0]        wa, wb;
    logic [DATA_W-1:0]        wda, wdb, wdc;
    logic [DEPTH-1:0]         wc;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic                     clr_req;
    logic [NUM_RD*DATA_W-1:0] rd0, rd1;
    logic                     busy0, done0, err0, busy1, done1, err1;

    always #5 clk = ~clk;

    zap_register_file_mp #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .BYPASS(1), .RD_REG(0)
    ) u_dut_byp (
        .i_clk(clk), .i_reset(rst), .i_wen(wen),
        .i_wr_addr_a(wa), .i_wr_data_a(wda),
        .i_wr_addr_b(wb), .i_wr_data_b(wdb),
        .i_wr_addr_c(wc), .i_wr_data_c(wdc),
        .i_rd_addr(rd_addr), .o_rd_data(rd0),
        .i_clr_req(clr_req), .o_clr_busy(busy0), .o_clr_done(done0),
        .o_addr_err(err0)
    );

    zap_register_file_mp #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .BYPASS(0), .RD_REG(1)
    ) u_dut_reg (
        .i_clk(clk), .i_reset(rst), .i_wen(wen),
        .i_wr_addr_a(wa), .i_wr_data_a(wda),
        .i_wr_addr_b(wb), .i_wr_data_b(wdb),
        .i_wr_addr_c(wc), .i_wr_data_c(wdc),
        .i_rd_addr(rd_addr), .o_rd_data(rd1),
        .i_clr_req(clr_req), .o_clr_busy(busy1), .o_clr_done(done1),
        .o_addr_err(err1)
    );

    // Model state: contents, clear position (-1 idle, 0..DEPTH-1 clearing
    // that entry, DEPTH = completion cycle), sticky error, registered reads.
    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] reg_exp [NUM_RD];
    int                clr_pos;
    logic              err_m;

    int checks;
    int errors;
    int n_busy;
    int n_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int e = 0; e < DEPTH; e++) mem[e] = '0;
        for (int k = 0; k < NUM_RD; k++) reg_exp[k] = '0;
        clr_pos = -1;
        err_m   = 1'b0;
    endtask

    task automatic zero_inputs();
        wen = 1'b0; wa = '0; wb = '0; wda = '0; wdb = '0;
        wc = '0; wdc = '0; rd_addr = '0; clr_req = 1'b0;
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return ADDR_W'($urandom_range(DEPTH, 63));
        return ADDR_W'($urandom_range(0, DEPTH - 1));
    endfunction

    // One clock cycle: compare all outputs at the falling edge against the
    // model, then advance the model at the rising edge.
    task automatic step();
        logic [DATA_W-1:0] nm [DEPTH];
        logic ev;
        int   ra;
        @(negedge clk);
        for (int e = 0; e < DEPTH; e++) nm[e] = mem[e];
        if (clr_pos >= 0 && clr_pos < DEPTH) nm[clr_pos] = '0;
        if (wen) begin
            if (int'(wa) < DEPTH) nm[wa] = wda;
            if (int'(wb) < DEPTH) nm[wb] = wdb;
        end
        for (int e = 0; e < DEPTH; e++) if (wc[e]) nm[e] = wdc;
        ev = wen && (int'(wa) >= DEPTH || int'(wb) >= DEPTH);
        for (int k = 0; k < NUM_RD; k++) begin
            ra = int'(rd_addr[k*ADDR_W +: ADDR_W]);
            if (ra >= DEPTH) ev = 1'b1;
            chk("rd_bypass", rd0[k*DATA_W +: DATA_W], (ra >= DEPTH) ? 32'h0 : nm[ra]);
            chk("rd_registered", rd1[k*DATA_W +: DATA_W], reg_exp[k]);
        end
        chk_bit("busy_byp", busy0, clr_pos >= 0 && clr_pos < DEPTH);
        chk_bit("busy_reg", busy1, clr_pos >= 0 && clr_pos < DEPTH);
        chk_bit("done_byp", done0, clr_pos == DEPTH);
        chk_bit("done_reg", done1, clr_pos == DEPTH);
        chk_bit("err_byp", err0, err_m);
        chk_bit("err_reg", err1, err_m);
        if (busy0) n_busy++;
        if (done0) n_done++;
        @(posedge clk);
        for (int k = 0; k < NUM_RD; k++) begin
            ra = int'(rd_addr[k*ADDR_W +: ADDR_W]);
            reg_exp[k] = (ra >= DEPTH) ? '0 : mem[ra];
        end
        for (int e = 0; e < DEPTH; e++) mem[e] = nm[e];
        if (ev) err_m = 1'b1;
        else if (clr_pos == DEPTH - 1) err_m = 1'b0;
        if (clr_pos < 0) begin
            if (clr_req) clr_pos = 0;
        end else if (clr_pos == DEPTH) begin
            clr_pos = -1;
        end else begin
            clr_pos++;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_bit("rst_busy", busy0, 1'b0);
        chk_bit("rst_done", done0, 1'b0);
        chk_bit("rst_err_byp", err0, 1'b0);
        chk_bit("rst_err_reg", err1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [63:0] r64;
        checks = 0; errors = 0; n_busy = 0; n_done = 0;
        rst = 1'b0;
        zero_inputs();
        model_reset();
        do_reset();

        // Reset contents on every port
        for (int e = 0; e < DEPTH; e++) begin
            rd_addr = {NUM_RD{ADDR_W'(e)}};
            step();
        end
        chk_bit("t1_err", err0, 1'b0);
        chk_bit("t1_busy", busy0, 1'b0);

        // Write priority C > B > A
        wen = 1'b1; wa = 6'd5; wda = 32'h11; wb = 6'd5; wdb = 32'h22;
        wc = '0; wc[5] = 1'b1; wdc = 32'h33; rd_addr = {NUM_RD{6'd5}};
        #2 chk("t2_c_wins", rd0[31:0], 32'h33);
        step();
        wc = '0;
        #2 chk("t2_b_wins", rd0[31:0], 32'h22);
        step();
        wen = 1'b0;
        #2 chk("t2_stored", rd0[31:0], 32'h22);
        chk("t2_model", mem[5], 32'h22);
        step();

        // Bypass vs stored value, registered read latency
        wen = 1'b1; wa = 6'd7; wda = 32'hDEAD; wb = 6'd7; wdb = 32'hDEAD;
        rd_addr = {NUM_RD{6'd7}};
        #2 chk("t3_bypass", rd0[31:0], 32'hDEAD);
        step();
        wa = 6'd9; wda = 32'hBEEF; wb = 6'd9; wdb = 32'hBEEF;
        #2 chk("t3_no_bypass_old", rd1[31:0], 32'h0);
        step();
        wen = 1'b0; rd_addr = {NUM_RD{6'd9}};
        #2 chk("t4_not_yet", rd1[31:0], 32'hDEAD);
        step();
        #2 chk("t4_latency1", rd1[31:0], 32'hBEEF);

        // Fill, soft clear, mid-clear write and ignored second request
        for (int e = 0; e < DEPTH; e += 2) begin
            wen = 1'b1;
            wa = ADDR_W'(e);     wda = $urandom | 32'h1;
            wb = ADDR_W'(e + 1); wdb = $urandom | 32'h1;
            rd_addr = {rand_addr(), rand_addr(), rand_addr(), rand_addr()} & {NUM_RD{6'h1F}};
            step();
        end
        wen = 1'b0;
        n_busy = 0; n_done = 0;
        clr_req = 1'b1;
        step();
        for (int i = 1; i <= DEPTH + 1; i++) begin
            clr_req = (i == 10);
            if (i == DEPTH) begin
                wen = 1'b1; wa = 6'd39; wda = 32'hCAFE0039; wb = 6'd39; wdb = 32'hCAFE0039;
            end else begin
                wen = 1'b0;
            end
            rd_addr = {NUM_RD{ADDR_W'($urandom_range(0, DEPTH - 1))}};
            step();
        end
        wen = 1'b0; clr_req = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("t5_busy_cycles", n_busy, DEPTH);
        chk("t5_done_pulses", n_done, 1);
        for (int e = 0; e < DEPTH; e++) begin
            rd_addr = {NUM_RD{ADDR_W'(e)}};
            step();
        end
        rd_addr = {6'd0, 6'd0, 6'd0, 6'd39};
        #2 chk("t5_kept", rd0[31:0], 32'hCAFE0039);
        chk("t5_cleared", rd0[63:32], 32'h0);
        step();

        // Out-of-range write, sticky error, reset mid-clear
        wen = 1'b1; wa = 6'd40; wda = 32'h1234; wb = 6'd40; wdb = 32'h5678;
        rd_addr = '0;
        step();
        wen = 1'b0;
        #2 chk_bit("t6_err_set", err0, 1'b1);
        for (int e = 0; e < DEPTH; e++) begin
            rd_addr = {NUM_RD{ADDR_W'(e)}};
            step();
        end
        chk_bit("t6_err_sticky", err0, 1'b1);
        rd_addr = '0;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 5; i++) step();
        do_reset();
        n_done = 0;
        for (int i = 0; i < DEPTH + 10; i++) step();
        chk("t6_no_done", n_done, 0);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            wen = 1'($urandom_range(0, 1));
            wa = rand_addr(); wb = rand_addr();
            wda = $urandom; wdb = $urandom; wdc = $urandom;
            case ($urandom_range(0, 7))
                5, 6: begin wc = '0; wc[$urandom_range(0, DEPTH - 1)] = 1'b1; end
                7: begin r64 = {$urandom, $urandom}; wc = r64[DEPTH-1:0]; end
                default: wc = '0;
            endcase
            for (int k = 0; k < NUM_RD; k++) rd_addr[k*ADDR_W +: ADDR_W] = rand_addr();
            clr_req = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
